// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver for the pll_clk domain.
// The raw line is double-flopped. Each bit is sampled near its middle using a
// clocks_per_bit counter, and received bytes are presented on a valid/ready port.
//
// Handshake: o_data/o_valid are held stable until a clock edge where
// o_valid & i_ready are both high; that edge transfers the byte.
// A byte that completes while o_valid is high and i_ready is low is dropped,
// and o_overrun pulses for one cycle.
module uart_rx #(
   parameter int clocks_per_bit = 80000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy,
   output logic [2:0] dbg_state
);

   localparam int cnt_w = $clog2(clocks_per_bit);
   localparam int half  = clocks_per_bit / 2;
   localparam logic [cnt_w-1:0] half_last = cnt_w'(half - 1);
   localparam logic [cnt_w-1:0] bit_last  = cnt_w'(clocks_per_bit - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t           state;
   logic [cnt_w-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             s1;
   logic             s2;

   // Two-flop synchroniser; idles high so reset never fakes a start bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= i_rx;
         s2 <= s1;
      end
   end

   // Receive FSM, output register and one-cycle error pulses.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= 3'd0;
         shift       <= 8'd0;
         o_data      <= 8'd0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
         // Consumer takes the byte; a delivery on this same edge overrides below.
         if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!s2) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == half_last) begin
                  cnt <= '0;
                  if (s2) begin
                     // Line went high again before mid start bit: glitch.
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == bit_last) begin
                  cnt   <= '0;
                  shift <= {s2, shift[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == bit_last) begin
                  cnt <= '0;
                  if (s2) begin
                     state <= IDLE;
                     if (!o_valid || i_ready) begin
                        o_data  <= shift;
                        o_valid <= 1'b1;
                     end else begin
                        o_overrun <= 1'b1;
                     end
                  end else begin
                     // Low stop bit: discard the byte and wait out the break.
                     o_frame_err <= 1'b1;
                     state       <= BRK;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BRK: begin
               if (s2) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy    = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx. Two instances are used: clocks_per_bit = 8 and 5 (odd half).
// Expected bytes are queued at send time, and a monitor pops them on each accepted transfer.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx8, rx5, rdy8, rdy5;
   logic [7:0] d8, d5;
   logic       v8, v5, fe8_o, fe5_o, ov8_o, ov5_o, busy8_o, busy5_o;
   logic [2:0] st8, st5;

   // Clock generation.
   always #5 clk = ~clk;

   uart_rx #(.clocks_per_bit(8)) dut8 (
      .clock(clk), .reset(reset), .i_rx(rx8), .o_data(d8), .o_valid(v8), .i_ready(rdy8),
      .o_frame_err(fe8_o), .o_overrun(ov8_o), .o_busy(busy8_o), .dbg_state(st8)
   );

   uart_rx #(.clocks_per_bit(5)) dut5 (
      .clock(clk), .reset(reset), .i_rx(rx5), .o_data(d5), .o_valid(v5), .i_ready(rdy5),
      .o_frame_err(fe5_o), .o_overrun(ov5_o), .o_busy(busy5_o), .dbg_state(st5)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int vcnt8, vcnt5, fe8, fe5, ov8, ov5, busy8;
   int e0 = 0;
   logic lat_arm = 1'b0;
   logic prev_v8 = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_q5[$];

   // Count posedges: after edge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_line(input int w, input logic v);
      if (w == 0) rx8 = v;
      else        rx5 = v;
   endtask

   // Drive one frame starting at the current negedge; leaves the line at stop_v.
   task automatic send(input int w, input logic [7:0] b, input logic stop_v);
      int n;
      n = (w == 0) ? 8 : 5;
      if (w == 0) e0 = cyc + 1;
      set_line(w, 1'b0);
      idle(n);
      for (int i = 0; i < 8; i++) begin
         set_line(w, b[i]);
         idle(n);
      end
      set_line(w, stop_v);
      idle(n);
   endtask

   task automatic clear_counts;
      vcnt8 = 0; vcnt5 = 0; fe8 = 0; fe5 = 0; ov8 = 0; ov5 = 0; busy8 = 0;
   endtask

   // Monitor: samples 1 time unit after each negedge. Inputs are stable at that point until the next posedge.
   always begin
      @(negedge clk);
      #1;
      if (!reset) begin
         if (v8) vcnt8++;
         if (v5) vcnt5++;
         if (fe8_o) fe8++;
         if (fe5_o) fe5++;
         if (ov8_o) ov8++;
         if (ov5_o) ov5++;
         if (busy8_o) busy8++;
         if (v8 && !prev_v8 && lat_arm) begin
            check("latency_e0_plus_78", cyc, e0 + 78);
            lat_arm = 1'b0;
         end
         prev_v8 = v8;
         if (v8 && rdy8) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_byte8: got 0x%0h expected none", d8);
            end else begin
               check("byte8", d8, exp_q.pop_front());
            end
         end
         if (v5 && rdy5) begin
            if (exp_q5.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_byte5: got 0x%0h expected none", d5);
            end else begin
               check("byte5", d5, exp_q5.pop_front());
            end
         end
      end else begin
         prev_v8 = 1'b0;
      end
   end

   initial begin
      logic [7:0] b;
      reset = 1'b1; rx8 = 1'b1; rx5 = 1'b1; rdy8 = 1'b0; rdy5 = 1'b1;
      clear_counts();
      @(negedge clk);
      idle(3);
      // Reset state.
      check("rst_data", d8, 0);
      check("rst_valid", v8, 0);
      check("rst_frame_err", fe8_o, 0);
      check("rst_overrun", ov8_o, 0);
      check("rst_busy", busy8_o, 0);
      check("rst_valid5", v5, 0);
      reset = 1'b0;
      idle(4);

      // 1: 0xA5 with ready high, latency E0+78.
      rdy8 = 1'b1; clear_counts();
      exp_q.push_back(8'hA5); lat_arm = 1'b1;
      send(0, 8'hA5, 1'b1);
      idle(4);
      check("t1_valid_cycles", vcnt8, 1);
      check("t1_latency_seen", lat_arm, 0);
      check("t1_frame_err", fe8, 0);
      check("t1_overrun", ov8, 0);
      check("t1_queue_empty", exp_q.size(), 0);

      // 2: overrun, 0x3C held and 0x81 dropped.
      rdy8 = 1'b0; clear_counts();
      exp_q.push_back(8'h3C);
      send(0, 8'h3C, 1'b1);
      send(0, 8'h81, 1'b1);
      idle(4);
      check("t2_data_held", d8, 8'h3C);
      check("t2_valid_held", v8, 1);
      check("t2_overrun_once", ov8, 1);
      check("t2_pending", exp_q.size(), 1);
      rdy8 = 1'b1;
      idle(2);
      check("t2_valid_cleared", v8, 0);
      check("t2_queue_empty", exp_q.size(), 0);

      // 3: stop bit low, line held low 40 bits, then recovery with 0x12.
      clear_counts();
      send(0, 8'h55, 1'b0);
      idle(40 * 8);
      rx8 = 1'b1;
      idle(16);
      check("t3_frame_err_once", fe8, 1);
      check("t3_no_valid", vcnt8, 0);
      check("t3_idle_state", st8, 0);
      exp_q.push_back(8'h12);
      send(0, 8'h12, 1'b1);
      idle(4);
      check("t3_recv_valid", vcnt8, 1);
      check("t3_frame_err_total", fe8, 1);
      check("t3_queue_empty", exp_q.size(), 0);

      // 4: 3-cycle low glitch on the idle line.
      clear_counts();
      rx8 = 1'b0;
      idle(3);
      rx8 = 1'b1;
      idle(20);
      check("t4_no_valid", vcnt8, 0);
      check("t4_no_frame_err", fe8, 0);
      check("t4_busy_seen", (busy8 > 0) ? 1 : 0, 1);
      check("t4_idle_state", st8, 0);

      // 5: back-to-back frames, clocks_per_bit = 5.
      clear_counts();
      exp_q5.push_back(8'h00); exp_q5.push_back(8'hFF); exp_q5.push_back(8'h7E);
      send(1, 8'h00, 1'b1);
      send(1, 8'hFF, 1'b1);
      send(1, 8'h7E, 1'b1);
      idle(4);
      check("t5_valid_count", vcnt5, 3);
      check("t5_frame_err", fe5, 0);
      check("t5_overrun", ov5, 0);
      check("t5_queue_empty", exp_q5.size(), 0);

      // 6: reset in the middle of the 0x99 data bits.
      rdy8 = 1'b1; clear_counts();
      b = 8'h99;
      rx8 = 1'b0;
      idle(8);
      for (int i = 0; i < 3; i++) begin
         rx8 = b[i];
         idle(8);
      end
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_data", d8, 0);
      check("t6_rst_valid", v8, 0);
      check("t6_rst_busy", busy8_o, 0);
      check("t6_rst_frame_err", fe8_o, 0);
      check("t6_rst_overrun", ov8_o, 0);
      check("t6_rst_state", st8, 0);
      rx8 = 1'b1;
      reset = 1'b0;
      idle(24);
      exp_q.push_back(8'h42);
      send(0, 8'h42, 1'b1);
      idle(4);
      check("t6_recv_valid", vcnt8, 1);
      check("t6_frame_err", fe8, 0);
      check("t6_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
